// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver: 1 start, 8 data (LSB first), 1 parity, 1 stop.
// Presents the received byte and error flags with an rxrdy / active-low read handshake.
module uart_receiver #(
   parameter bit PARITY_ODD = 1'b1
) (
   input  logic       mclkx16,
   input  logic       reset,
   input  logic       rx,
   input  logic       read,
   output logic       rxrdy,
   output logic [7:0] dataout,
   output logic       parityerr,
   output logic       framingerr,
   output logic       overrun
);

   // state  | meaning
   // IDLE   | line idle, waiting for a falling edge on rx_s
   // START  | validating the start bit at its midpoint
   // DATA   | sampling 8 data bits at mid-bit, LSB first
   // PARITY | sampling the parity bit
   // STOP   | sampling the stop bit, then completing the frame
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;

   logic       sync1_q, sync1_d;
   logic       sync2_q, sync2_d;
   logic       rx_prev_q, rx_prev_d;
   logic [2:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q, shift_d;
   logic       par_q, par_d;
   logic       rxrdy_q, rxrdy_d;
   logic [7:0] data_q, data_d;
   logic       pe_q, pe_d;
   logic       fe_q, fe_d;
   logic       ovr_q, ovr_d;

   logic       rx_s;
   logic       accept;
   logic       done;

   assign rx_s   = sync2_q;
   assign accept = ~read & rxrdy_q;

   always_comb begin
      sync1_d   = rx;
      sync2_d   = sync1_q;
      rx_prev_d = rx_s;
      state_d   = state_q;
      cnt_d     = cnt_q + 4'd1;
      idx_d     = idx_q;
      shift_d   = shift_q;
      par_d     = par_q;
      rxrdy_d   = rxrdy_q;
      data_d    = data_q;
      pe_d      = pe_q;
      fe_d      = fe_q;
      ovr_d     = ovr_q;
      done      = 1'b0;

      case (state_q)
         IDLE: begin
            // cnt reads 0 on the edge clock, so it tracks clocks since the edge
            cnt_d = 4'd0;
            if (rx_prev_q && !rx_s) begin
               cnt_d   = 4'd1;
               state_d = START;
            end
         end
         START: begin
            if (cnt_q == 4'd7) begin
               cnt_d = 4'd0;
               if (rx_s) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  idx_d   = 3'd0;
               end
            end
         end
         DATA: begin
            if (cnt_q == 4'd15) begin
               shift_d[idx_q] = rx_s;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (cnt_q == 4'd15) begin
               par_d   = rx_s;
               state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == 4'd15) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         rxrdy_d = 1'b0;
         ovr_d   = 1'b0;
      end

      // completion beats a same-cycle read; the old byte then counts as read
      if (done) begin
         data_d  = shift_q;
         pe_d    = par_q != (^shift_q ^ PARITY_ODD);
         fe_d    = ~rx_s;
         rxrdy_d = 1'b1;
         if (rxrdy_q && !accept) ovr_d = 1'b1;
      end
   end

   always_ff @(posedge mclkx16 or posedge reset) begin
      if (reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         idx_q     <= 3'd0;
         shift_q   <= 8'h00;
         par_q     <= 1'b0;
         rxrdy_q   <= 1'b0;
         data_q    <= 8'h00;
         pe_q      <= 1'b0;
         fe_q      <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         rx_prev_q <= rx_prev_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         rxrdy_q   <= rxrdy_d;
         data_q    <= data_d;
         pe_q      <= pe_d;
         fe_q      <= fe_d;
         ovr_q     <= ovr_d;
      end
   end

   assign rxrdy      = rxrdy_q;
   assign dataout    = data_q;
   assign parityerr  = pe_q;
   assign framingerr = fe_q;
   assign overrun    = ovr_q;

endmodule
